logic_ram_pipe: RTL and testbench

- Next-generation AXI-MM backing RAM with byte-strobed writes, depth derived from the address width, and read latency selectable at 1 or 2 cycles with an explicit read-valid strobe.
- A built-in clear engine zeroes the whole array after reset or on request, and reports busy while it runs.
- Sits behind the AXI4 slave register/handshake logic, which drives mem_wren/mem_rden/mem_address and captures axi_rdata when rdata_valid is high.

---
 rtl/logic_ram_pipe.sv | 170 +++++++++++++++++
 tb/tb_logic_ram_pipe.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_ram_pipe.sv
// logic_ram_pipe: AXI-MM backing RAM with byte-strobed writes, a clear engine
// that zeroes the array after reset or on request, and a 1- or 2-cycle read
// pipeline with a read-valid strobe.
// Optional feature macro: LOGIC_RAM_PARITY_EN (per-byte even parity check).
module logic_ram_pipe #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int OPT_MEM_ADDR_BITS  = 10,
    parameter int RD_LATENCY         = 1,
    parameter bit CLEAR_ON_RESET     = 1'b1
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESET,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic                            mem_wren,
    input  logic                            mem_rden,
    input  logic [OPT_MEM_ADDR_BITS:0]      mem_address,
    input  logic                            clear_req,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   axi_rdata,
    output logic                            rdata_valid,
    output logic                            mem_busy,
    output logic                            parity_err
);
    localparam int DATA_W = C_S_AXI_DATA_WIDTH;
    localparam int NB     = DATA_W / 8;
    localparam int AW     = OPT_MEM_ADDR_BITS + 1;
    localparam int DEPTH  = 1 << AW;

    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
        $error("logic_ram_pipe: RD_LATENCY must be 1 or 2");
    end
    if ((DATA_W % 8) != 0) begin : g_bad_width
        $error("logic_ram_pipe: C_S_AXI_DATA_WIDTH must be a multiple of 8");
    end

    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

    state_t            state;
    state_t            state_next;
    logic [AW-1:0]     cnt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              rd_en;
    logic [DATA_W-1:0] rd_word;
    logic              rd_perr;

`ifdef LOGIC_RAM_PARITY_EN
    logic [NB-1:0] par [DEPTH];

    // True when any byte's recomputed even parity disagrees with its stored bit
    function automatic logic parity_mismatch(input logic [DATA_W-1:0] word,
                                             input logic [NB-1:0]     stored);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < NB; i++) begin
            bad = bad | ((^word[8*i +: 8]) ^ stored[i]);
        end
        return bad;
    endfunction
`endif

    // Host accesses are locked out for the whole clear sweep
    assign mem_busy = (state == CLEAR);
    assign rd_en    = mem_rden & ~mem_busy;

    // FSM state register
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            state <= CLEAR_ON_RESET ? CLEAR : IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state: a request while already clearing is ignored
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (clear_req) state_next = CLEAR;
            CLEAR:   if (&cnt)      state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Clear counter: restarts at 0 per sweep, parks on the last address after
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            cnt <= '0;
        end else if (state == IDLE && clear_req) begin
            cnt <= '0;
        end else if (state == CLEAR && !(&cnt)) begin
            cnt <= cnt + AW'(1);
        end
    end

    // Array write: the sweep owns the write port while busy, else strobed host writes
    always_ff @(posedge S_AXI_ACLK) begin
        if (mem_busy) begin
            mem[cnt] <= '0;
        end else if (mem_wren) begin
            for (int i = 0; i < NB; i++) begin
                if (S_AXI_WSTRB[i]) mem[mem_address][8*i +: 8] <= S_AXI_WDATA[8*i +: 8];
            end
        end
    end

`ifdef LOGIC_RAM_PARITY_EN
    // Parity bits follow their byte's strobe; the sweep stores parity 0 for zero data
    always_ff @(posedge S_AXI_ACLK) begin
        if (mem_busy) begin
            par[cnt] <= '0;
        end else if (mem_wren) begin
            for (int i = 0; i < NB; i++) begin
                if (S_AXI_WSTRB[i]) par[mem_address][i] <= ^S_AXI_WDATA[8*i +: 8];
            end
        end
    end
    assign rd_perr = parity_mismatch(rd_word, par[mem_address]);
`else
    assign rd_perr = 1'b0;
`endif

    // Read port samples the pre-write word, so same-address read+write is read-first
    assign rd_word = mem[mem_address];

    if (RD_LATENCY == 1) begin : g_lat1
        // Single output stage; data holds between reads
        always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
            if (S_AXI_ARESET) begin
                axi_rdata   <= '0;
                rdata_valid <= 1'b0;
                parity_err  <= 1'b0;
            end else begin
                rdata_valid <= rd_en;
                parity_err  <= rd_en & rd_perr;
                if (rd_en) axi_rdata <= rd_word;
            end
        end
    end else begin : g_lat2
        logic [DATA_W-1:0] data_p0;
        logic              vld_p0;
        logic              perr_p0;

        // Stage p0: capture the addressed word
        always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
            if (S_AXI_ARESET) begin
                data_p0 <= '0;
                vld_p0  <= 1'b0;
                perr_p0 <= 1'b0;
            end else begin
                vld_p0  <= rd_en;
                perr_p0 <= rd_en & rd_perr;
                if (rd_en) data_p0 <= rd_word;
            end
        end

        // Output stage: forward p0; data holds between reads
        always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
            if (S_AXI_ARESET) begin
                axi_rdata   <= '0;
                rdata_valid <= 1'b0;
                parity_err  <= 1'b0;
            end else begin
                rdata_valid <= vld_p0;
                parity_err  <= perr_p0;
                if (vld_p0) axi_rdata <= data_p0;
            end
        end
    end

endmodule

// File: tb/tb_logic_ram_pipe.sv
// Testbench for logic_ram_pipe: two instances (read latency 1 and 2) share all
// inputs and are compared every cycle against a behavioural RAM model, plus
// directed scenarios with fixed expected values.
module tb_logic_ram_pipe;
    localparam int AB    = 3;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        wren, rden, clear_req;
    logic [3:0]  addr;
    logic [31:0] rdata1, rdata2;
    logic        vld1, vld2, busy1, busy2, perr1, perr2;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned cyc = 0;
    bit          par_skip = 1'b0;

    typedef struct { int unsigned c; logic [31:0] d; } cap_t;
    cap_t cap2[$];

    always #5 clk = ~clk;

    logic_ram_pipe #(.C_S_AXI_DATA_WIDTH(32), .OPT_MEM_ADDR_BITS(AB),
                     .RD_LATENCY(1), .CLEAR_ON_RESET(1'b1)) dut1 (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(rst), .S_AXI_WSTRB(wstrb), .S_AXI_WDATA(wdata),
        .mem_wren(wren), .mem_rden(rden), .mem_address(addr), .clear_req(clear_req),
        .axi_rdata(rdata1), .rdata_valid(vld1), .mem_busy(busy1), .parity_err(perr1));

    logic_ram_pipe #(.C_S_AXI_DATA_WIDTH(32), .OPT_MEM_ADDR_BITS(AB),
                     .RD_LATENCY(2), .CLEAR_ON_RESET(1'b1)) dut2 (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(rst), .S_AXI_WSTRB(wstrb), .S_AXI_WDATA(wdata),
        .mem_wren(wren), .mem_rden(rden), .mem_address(addr), .clear_req(clear_req),
        .axi_rdata(rdata2), .rdata_valid(vld2), .mem_busy(busy2), .parity_err(perr2));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    logic [31:0] ref_mem [DEPTH];
    int          busy_left;
    logic        acc;
    logic [31:0] rw;
    logic        e1_vld, e2_pend, e2_vld;
    logic [31:0] e1_data, e2_pend_d, e2_data;

    always @(posedge clk) cyc++;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_left = DEPTH;
            e1_vld = 1'b0; e1_data = '0;
            e2_pend = 1'b0; e2_pend_d = '0;
            e2_vld = 1'b0; e2_data = '0;
        end else begin
            acc = (busy_left == 0) && rden;
            rw  = ref_mem[addr];
            e2_vld = e2_pend;
            if (e2_pend) e2_data = e2_pend_d;
            e2_pend = acc;
            if (acc) e2_pend_d = rw;
            e1_vld = acc;
            if (acc) e1_data = rw;
            if (busy_left > 0) begin
                ref_mem[DEPTH - busy_left] = '0;
                busy_left--;
            end else begin
                if (wren)
                    for (int i = 0; i < 4; i++)
                        if (wstrb[i]) ref_mem[addr][8*i +: 8] = wdata[8*i +: 8];
                if (clear_req) busy_left = DEPTH;
            end
        end
    end

    always @(negedge clk) begin
        check("busy1", 32'(busy1), 32'(busy_left != 0));
        check("busy2", 32'(busy2), 32'(busy_left != 0));
        check("vld1", 32'(vld1), 32'(e1_vld));
        check("vld2", 32'(vld2), 32'(e2_vld));
        check("rdata1", rdata1, e1_data);
        check("rdata2", rdata2, e2_data);
        if (!par_skip) begin
            check("perr1", 32'(perr1), 32'(0));
            check("perr2", 32'(perr2), 32'(0));
        end
        if (vld2) cap2.push_back('{cyc, rdata2});
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        wren = 1'b1; addr = a; wdata = d; wstrb = s;
        tick();
        wren = 1'b0;
    endtask

    task automatic rd1(input logic [3:0] a, output logic [31:0] d);
        bit seen;
        rden = 1'b1; addr = a;
        tick();
        rden = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (vld1) seen = 1'b1;
        end
        check("rd_seen", 32'(seen), 32'(1));
        d = rdata1;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy1) n++;
            else break;
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] d;
        int          n, c0;
        rst = 1'b1; wren = 0; rden = 0; clear_req = 0; addr = 0; wdata = 0; wstrb = 0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rdata", rdata1, 32'h0);
        check("rst_vld", 32'(vld1), 32'(0));
        check("rst_busy", 32'(busy1), 32'(1));
        @(posedge clk); #1;
        rst = 1'b0;
        count_busy(n);
        check("busy_after_reset", n, 16);
        tick();

        rd1(4'd5, d);
        check("addr5_cleared", d, 32'h0);

        wr(4'd3, 32'hAABBCCDD, 4'hF);
        wr(4'd3, 32'h11223344, 4'h5);
        rd1(4'd3, d);
        check("strobe_merge", d, 32'hAA22CC44);
        wr(4'd3, 32'hDEADBEEF, 4'h0);
        rd1(4'd3, d);
        check("strobe_zero_noop", d, 32'hAA22CC44);

        wr(4'd7, 32'h12345678, 4'hF);
        wren = 1'b1; rden = 1'b1; addr = 4'd7; wdata = 32'hCAFEF00D; wstrb = 4'hF;
        tick();
        wren = 1'b0; rden = 1'b0;
        @(negedge clk); #1;
        check("rw_same_vld", 32'(vld1), 32'(1));
        check("rw_same_old", rdata1, 32'h12345678);
        rd1(4'd7, d);
        check("rw_same_new", d, 32'hCAFEF00D);

        // Latency-2 burst of three back-to-back reads
        wr(4'd0, 32'hA0A0A0A0, 4'hF);
        wr(4'd1, 32'hB1B1B1B1, 4'hF);
        wr(4'd2, 32'hC2C2C2C2, 4'hF);
        cap2.delete();
        c0 = int'(cyc);
        rden = 1'b1; addr = 4'd0; tick();
        addr = 4'd1; tick();
        addr = 4'd2; tick();
        rden = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check("lat2_count", cap2.size(), 3);
        if (cap2.size() == 3) begin
            check("lat2_c0", cap2[0].c, c0 + 2);
            check("lat2_c1", cap2[1].c, c0 + 3);
            check("lat2_c2", cap2[2].c, c0 + 4);
            check("lat2_d0", cap2[0].d, 32'hA0A0A0A0);
            check("lat2_d1", cap2[1].d, 32'hB1B1B1B1);
            check("lat2_d2", cap2[2].d, 32'hC2C2C2C2);
        end
        @(posedge clk); #1;

        // Clear with re-request mid-sweep, then reset at sweep cycle 8
        for (int i = 0; i < DEPTH; i++) wr(4'(i), 32'hFFFFFFFF, 4'hF);
        clear_req = 1'b1; tick(); clear_req = 1'b0;
        rden = 1'b1; addr = 4'd4; tick(); rden = 1'b0;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            if (vld1 || vld2) n++;
        end
        check("busy_read_ignored", n, 0);
        @(posedge clk); #1;
        clear_req = 1'b1; tick(); clear_req = 1'b0;
        repeat (2) tick();
        check("busy_mid_sweep", 32'(busy1), 32'(1));
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        count_busy(n);
        check("busy_after_abort", n, 16);
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            rd1(4'(i), d);
            check("clear_zero", d, 32'h0);
        end
        @(posedge clk); #1;

        // Clear request ignored while already clearing: sweep length unchanged
        wr(4'd9, 32'h5A5A5A5A, 4'hF);
        clear_req = 1'b1; tick(); clear_req = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy1) n++;
            else break;
            clear_req = (n == 5);
        end
        clear_req = 1'b0;
        check("busy_rereq_len", n, 16);
        @(posedge clk); #1;
        rd1(4'd9, d);
        check("clear_addr9", d, 32'h0);
        @(posedge clk); #1;

`ifdef LOGIC_RAM_PARITY_EN
        wr(4'd9, 32'h00000001, 4'h1);
        par_skip = 1'b1;
        dut1.mem[9][0] = ~dut1.mem[9][0];
        dut2.mem[9][0] = ~dut2.mem[9][0];
        ref_mem[9][0] = ~ref_mem[9][0];
        rd1(4'd9, d);
        check("par_err_vld", 32'(vld1), 32'(1));
        check("par_err_flag", 32'(perr1), 32'(1));
        rd1(4'd10, d);
        check("par_ok_flag", 32'(perr1), 32'(0));
        repeat (3) tick();
        par_skip = 1'b0;
`endif

        // Randomized traffic checked cycle by cycle against the model
        for (int i = 0; i < 600; i++) begin
            wren      = ($urandom_range(0, 2) == 0);
            rden      = ($urandom_range(0, 1) == 0);
            addr      = 4'($urandom_range(0, DEPTH - 1));
            wdata     = $urandom;
            wstrb     = 4'($urandom_range(0, 15));
            clear_req = ($urandom_range(0, 59) == 0);
            tick();
        end
        wren = 0; rden = 0; clear_req = 0;
        repeat (20) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
